// File: rtl/md_if.sv
// Pipeline <-> multiply/divide sequencer signal bundle.
// The master modport is the EX stage side; the slave modport is the sequencer.
interface md_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              is_mult;
  logic              is_unsigned;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              lhr_ren;
  logic              busy;
  logic              stall;
  logic              hilo_wen;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;
  logic              div_by_zero;

  modport master (
    output start, is_mult, is_unsigned, op_a, op_b, lhr_ren,
    input  busy, stall, hilo_wen, hi_wdata, lo_wdata, div_by_zero
  );

  modport slave (
    input  start, is_mult, is_unsigned, op_a, op_b, lhr_ren,
    output busy, stall, hilo_wen, hi_wdata, lo_wdata, div_by_zero
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative radix-2 shift-add multiply / restoring divide with Hi/Lo writeback
// and structural/data hazard stall generation for the EX stage.
//
// state | meaning
// IDLE  | no operation in flight; a start is accepted here
// CALC  | one multiplier bit or quotient bit per cycle, DATA_W cycles
// DONE  | result registered, hilo_wen pulses, back to IDLE next cycle
module md_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic clk,
  input  logic rst,
  md_if.slave  md
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                op_mult;
  logic                neg_res;
  logic                neg_rem;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic                hilo_wen_q;
  logic                dbz_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic                sign_a;
  logic                sign_b;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_diff;
  logic [DATA_W-1:0]   step_hi;
  logic [DATA_W-1:0]   step_lo;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                last_iter;

  always_comb begin
    sign_a   = !md.is_unsigned && md.op_a[DATA_W-1];
    sign_b   = !md.is_unsigned && md.op_b[DATA_W-1];
    abs_a    = sign_a ? -md.op_a : md.op_a;
    abs_b    = sign_b ? -md.op_b : md.op_b;

    // acc_hi:acc_lo is the partial product (mult) or remainder:dividend-shift (div)
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    div_diff = {acc_hi, acc_lo[DATA_W-1]} - {1'b0, opnd};

    step_hi  = '0;
    step_lo  = '0;
    if (op_mult) begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end else if (!div_diff[DATA_W]) begin
      step_hi = div_diff[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], 1'b1};
    end else begin
      step_hi = {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
      step_lo = {acc_lo[DATA_W-2:0], 1'b0};
    end

    prod_fix  = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
    quo_fix   = neg_res ? -step_lo : step_lo;
    rem_fix   = neg_rem ? -step_hi : step_hi;
    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_mult    <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      opnd       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      hilo_wen_q <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      hilo_wen_q <= 1'b0;
      dbz_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md.start) begin
            op_mult <= md.is_mult;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            cnt     <= '0;
            acc_hi  <= '0;
            if (!md.is_mult && (md.op_b == '0)) begin
              state      <= S_DONE;
              hilo_wen_q <= 1'b1;
              dbz_q      <= 1'b1;
              hi_q       <= md.op_a;
              lo_q       <= '1;
              acc_lo     <= '0;
              opnd       <= '0;
            end else begin
              state  <= S_CALC;
              opnd   <= md.is_mult ? abs_a : abs_b;
              acc_lo <= md.is_mult ? abs_b : abs_a;
            end
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            state      <= S_DONE;
            hilo_wen_q <= 1'b1;
            if (op_mult) begin
              hi_q <= prod_fix[2*DATA_W-1:DATA_W];
              lo_q <= prod_fix[DATA_W-1:0];
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md.busy        = (state != S_IDLE);
  assign md.stall       = md.busy && (md.start || md.lhr_ren);
  assign md.hilo_wen    = hilo_wen_q;
  assign md.div_by_zero = dbz_q;
  assign md.hi_wdata    = hi_q;
  assign md.lo_wdata    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized and directed bench for md_sequencer, checked against a
// plain-arithmetic multiply/divide model.
module tb_md_sequencer;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  md_if #(.DATA_W(32)) m ();

  md_sequencer #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_md(input logic mult, input logic uns,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    dbz = 1'b0;
    if (mult) begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
      end
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dbz = 1'b1;
      hi  = a;
      lo  = 32'hFFFF_FFFF;
    end else begin
      if (uns) begin
        sa = {32'b0, a};
        sb = {32'b0, b};
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one op in an idle cycle and waits for the write strobe; lat counts the accept cycle as 1.
  task automatic run_op(input logic mult, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dbz, output logic acc_stall);
    @(negedge clk);
    m.start = 1'b1; m.is_mult = mult; m.is_unsigned = uns; m.op_a = a; m.op_b = b;
    #1 acc_stall = m.stall;
    lat = 0;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      m.start = 1'b0;
      m.is_mult = 1'($urandom); m.is_unsigned = 1'($urandom);
      m.op_a = $urandom; m.op_b = $urandom;
      if (m.hilo_wen) begin
        lat = c;
        break;
      end
    end
    hi = m.hi_wdata; lo = m.lo_wdata; dbz = m.div_by_zero;
  endtask

  task automatic test_reset();
    m.start = 1'b0; m.is_mult = 1'b0; m.is_unsigned = 1'b0;
    m.op_a = '0; m.op_b = '0; m.lhr_ren = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    m.lhr_ren = 1'b1;
    #1;
    checks++;
    if ({m.busy, m.stall, m.hilo_wen, m.div_by_zero} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {m.busy, m.stall, m.hilo_wen, m.div_by_zero});
    end
    checks++;
    if ({m.hi_wdata, m.lo_wdata} !== 64'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {m.hi_wdata, m.lo_wdata});
    end
    m.lhr_ren = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] vb [5] = '{32'hFFFF_FFFF, 32'd7,         32'd2,         32'd0,   32'hFFFF_FFFF};
    logic        vm [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vu [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd0};
    logic [31:0] elo [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int          elat [5] = '{34, 34, 34, 2, 34};
    int          lat;
    logic [31:0] hi, lo;
    logic        dbz, acc_stall;
    for (int i = 0; i < 5; i++) begin
      run_op(vm[i], vu[i], va[i], vb[i], lat, hi, lo, dbz, acc_stall);
      checks++;
      if (lat !== elat[i]) begin
        errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat[i]);
      end
      checks++;
      if ({hi, lo} !== {ehi[i], elo[i]}) begin
        errors++; $display("FAIL dir%0d_hilo got=%h_%h exp=%h_%h", i, hi, lo, ehi[i], elo[i]);
      end
      checks++;
      if (dbz !== (i == 3)) begin
        errors++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dbz, (i == 3));
      end
      checks++;
      if (acc_stall !== 1'b0) begin
        errors++; $display("FAIL dir%0d_accept_stall got=%b exp=0", i, acc_stall);
      end
      @(negedge clk);
      checks++;
      if ({m.hilo_wen, m.div_by_zero, m.busy} !== 3'b000) begin
        errors++; $display("FAIL dir%0d_after_done got=%b exp=000", i, {m.hilo_wen, m.div_by_zero, m.busy});
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({m.hi_wdata, m.lo_wdata} !== {ehi[4], elo[4]}) begin
      errors++; $display("FAIL hold_result got=%h_%h exp=%h_%h", m.hi_wdata, m.lo_wdata, ehi[4], elo[4]);
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] a, b, hi, lo, ehi, elo;
    logic        mult, uns, dbz, edbz, acc_stall;
    for (int i = 0; i < 30; i++) begin
      mult = 1'($urandom); uns = 1'($urandom);
      a = pick_val(); b = pick_val();
      ref_md(mult, uns, a, b, ehi, elo, edbz);
      run_op(mult, uns, a, b, lat, hi, lo, dbz, acc_stall);
      checks++;
      if (lat !== ((!mult && b == 0) ? 2 : 34)) begin
        errors++; $display("FAIL rnd%0d_latency got=%0d m=%b a=%h b=%h", i, lat, mult, a, b);
      end
      checks++;
      if ({hi, lo, dbz} !== {ehi, elo, edbz}) begin
        errors++;
        $display("FAIL rnd%0d_result m=%b u=%b a=%h b=%h got=%h_%h_%b exp=%h_%h_%b",
                 i, mult, uns, a, b, hi, lo, dbz, ehi, elo, edbz);
      end
    end
  endtask

  task automatic test_stall_mfhi();
    logic [31:0] a, b, ehi, elo;
    logic        edbz;
    int          stall_cnt = 0, lat = 0;
    logic        stall_after = 1'b1;
    a = $urandom; b = $urandom;
    ref_md(1'b1, 1'b0, a, b, ehi, elo, edbz);
    @(negedge clk);
    m.start = 1'b1; m.is_mult = 1'b1; m.is_unsigned = 1'b0; m.op_a = a; m.op_b = b;
    for (int c = 2; c <= 36; c++) begin
      @(negedge clk);
      m.start = 1'b0; m.op_a = $urandom; m.op_b = $urandom;
      if (m.hilo_wen) lat = c;
      m.lhr_ren = 1'b1;
      #1;
      if (c <= 34 && m.stall) stall_cnt++;
      if (c == 35) begin
        stall_after = m.stall;
        checks++;
        if (m.hi_wdata !== ehi || m.lo_wdata !== elo) begin
          errors++; $display("FAIL mfhi_read got=%h_%h exp=%h_%h", m.hi_wdata, m.lo_wdata, ehi, elo);
        end
      end
    end
    m.lhr_ren = 1'b0;
    checks++;
    if (stall_cnt !== 33) begin
      errors++; $display("FAIL mfhi_stall_cycles got=%0d exp=33", stall_cnt);
    end
    checks++;
    if (stall_after !== 1'b0) begin
      errors++; $display("FAIL mfhi_stall_release got=%b exp=0", stall_after);
    end
    checks++;
    if (lat !== 34) begin
      errors++; $display("FAIL mfhi_latency got=%0d exp=34", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, ehi1, elo1, ehi2, elo2, hi1, lo1, hi2, lo2;
    logic        edbz;
    int          lat1 = 0, lat2 = 0, stall_cnt = 0;
    logic        stall35 = 1'b1;
    a1 = $urandom; b1 = $urandom; a2 = pick_val(); b2 = pick_val();
    ref_md(1'b1, 1'b0, a1, b1, ehi1, elo1, edbz);
    ref_md(1'b1, 1'b0, a2, b2, ehi2, elo2, edbz);
    hi1 = '0; lo1 = '0; hi2 = '0; lo2 = '0;
    @(negedge clk);
    m.start = 1'b1; m.is_mult = 1'b1; m.is_unsigned = 1'b0; m.op_a = a1; m.op_b = b1;
    for (int c = 2; c <= 120; c++) begin
      @(negedge clk);
      if (m.hilo_wen) begin
        if (lat1 == 0) begin
          lat1 = c; hi1 = m.hi_wdata; lo1 = m.lo_wdata;
        end else begin
          lat2 = c; hi2 = m.hi_wdata; lo2 = m.lo_wdata;
          break;
        end
      end
      if (c == 2) begin m.op_a = a2; m.op_b = b2; end
      if (c == 36) begin m.start = 1'b0; m.op_a = $urandom; m.op_b = $urandom; end
      #1;
      if (c <= 34 && m.stall) stall_cnt++;
      if (c == 35) stall35 = m.stall;
    end
    checks++;
    if (stall_cnt !== 33 || stall35 !== 1'b0) begin
      errors++; $display("FAIL b2b_stall got=%0d/%b exp=33/0", stall_cnt, stall35);
    end
    checks++;
    if (lat1 !== 34 || {hi1, lo1} !== {ehi1, elo1}) begin
      errors++; $display("FAIL b2b_first got=%0d %h_%h exp=34 %h_%h", lat1, hi1, lo1, ehi1, elo1);
    end
    checks++;
    if (lat2 !== 68 || {hi2, lo2} !== {ehi2, elo2}) begin
      errors++; $display("FAIL b2b_second got=%0d %h_%h exp=68 %h_%h", lat2, hi2, lo2, ehi2, elo2);
    end
  endtask

  task automatic test_reset_mid();
    int          strobes = 0, lat;
    logic [31:0] hi, lo, ehi, elo;
    logic        dbz, edbz, acc_stall;
    @(negedge clk);
    m.start = 1'b1; m.is_mult = 1'b1; m.is_unsigned = 1'b1; m.op_a = $urandom; m.op_b = $urandom;
    @(negedge clk);
    m.start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (m.busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy_before got=%b exp=1", m.busy);
    end
    rst = 1'b1; m.lhr_ren = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({m.busy, m.stall, m.hilo_wen, m.div_by_zero} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got=%b exp=0000", {m.busy, m.stall, m.hilo_wen, m.div_by_zero});
    end
    rst = 1'b0; m.lhr_ren = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m.hilo_wen || m.div_by_zero) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL rstmid_no_strobe got=%0d exp=0", strobes);
    end
    ref_md(1'b0, 1'b0, 32'hFFFF_FF00, 32'd9, ehi, elo, edbz);
    run_op(1'b0, 1'b0, 32'hFFFF_FF00, 32'd9, lat, hi, lo, dbz, acc_stall);
    checks++;
    if (lat !== 34 || {hi, lo, dbz} !== {ehi, elo, edbz}) begin
      errors++; $display("FAIL rstmid_rerun got=%0d %h_%h_%b exp=34 %h_%h_%b", lat, hi, lo, dbz, ehi, elo, edbz);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_mfhi();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
